// File: rtl/fwnoc_pkg.sv
// ----------------------------------------------------------------------------
// fwnoc_pkg
// Shared fwnoc types and constants: default flit width, where the payload
// length field sits in a header flit, and the output-arbiter state encoding.
// No ports.
// ----------------------------------------------------------------------------
package fwnoc_pkg;

    localparam int FWNOC_FLIT_W  = 32;
    localparam int FWNOC_LEN_LSB = 0;
    localparam int FWNOC_LEN_W   = 8;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_HEAD,
        ARB_BODY
    } fwnoc_arb_state_t;

endpackage

// File: rtl/fwnoc_rr_pick.sv
// ----------------------------------------------------------------------------
// fwnoc_rr_pick
// Combinational round-robin picker. It scans the requests starting at
// i_last+1, wraps around, and returns the first active requester. i_last
// itself has the lowest priority. This block is also used by the router's
// input-VC allocator.
//   i_req    [N]  request vector
//   i_last   [W]  index of the previous winner
//   o_gnt_id [W]  index of the selected requester (valid when o_any=1)
//   o_any         at least one request is active
// ----------------------------------------------------------------------------
module fwnoc_rr_pick #(
    parameter int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_last,
    output logic [W-1:0] o_gnt_id,
    output logic         o_any
);

    int         w_sum;
    logic [W-1:0] w_idx;

    // Walk the offsets from farthest to nearest so the nearest requester
    // after i_last is the last one written, and therefore the one that wins.
    always_comb begin
        o_gnt_id = '0;
        o_any    = 1'b0;
        w_sum    = 0;
        w_idx    = '0;
        for (int off = N; off >= 1; off--) begin
            w_sum = (int'(i_last) + off) % N;
            w_idx = W'(w_sum);
            if (i_req[w_idx]) begin
                o_gnt_id = w_idx;
                o_any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fwnoc_out_arb.sv
// ----------------------------------------------------------------------------
// fwnoc_out_arb
// Wormhole output-port arbiter. N_PORTS ready/valid flit sources share one
// ready/valid output. The arbiter grants round-robin on packet boundaries and
// holds the grant until the packet's tail flit transfers, so flits from
// different packets never interleave.
//   clock               rising-edge clock
//   reset               asynchronous active-low reset
//   i_valid  [N]        per-port flit valid
//   i_ready  [N]        per-port flit accept (only the granted port can see 1)
//   i_dat    [N*DW]     per-port flit, port k at [k*DW +: DW]
//   o_valid             output flit valid
//   o_ready             output flit accept
//   o_dat    [DW]       output flit (zero while o_valid=0)
//   o_gnt_id [log2 N]   granted port (meaningful while o_busy=1)
//   o_busy              a grant is held
// ----------------------------------------------------------------------------
module fwnoc_out_arb
    import fwnoc_pkg::*;
#(
    parameter int N_PORTS    = 4,
    parameter int DATA_WIDTH = FWNOC_FLIT_W,
    parameter int LEN_LSB    = FWNOC_LEN_LSB,
    parameter int LEN_W      = FWNOC_LEN_W,
    localparam int GW = $clog2(N_PORTS)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [N_PORTS-1:0]            i_valid,
    output logic [N_PORTS-1:0]            i_ready,
    input  logic [N_PORTS*DATA_WIDTH-1:0] i_dat,
    output logic                          o_valid,
    input  logic                          o_ready,
    output logic [DATA_WIDTH-1:0]         o_dat,
    output logic [GW-1:0]                 o_gnt_id,
    output logic                          o_busy
);

    fwnoc_arb_state_t r_state;
    logic [GW-1:0]    r_gnt;
    logic [GW-1:0]    r_last;
    logic [LEN_W-1:0] r_remain;

    logic [GW-1:0]         w_pick;
    logic                  w_any;
    logic                  w_sel_valid;
    logic [DATA_WIDTH-1:0] w_sel_dat;
    logic                  w_xfer;
    logic [LEN_W-1:0]      w_len;

    fwnoc_rr_pick #(.N(N_PORTS)) u_pick (
        .i_req    (i_valid),
        .i_last   (r_last),
        .o_gnt_id (w_pick),
        .o_any    (w_any)
    );

    // Select the granted port with constant indices. This also works when
    // N_PORTS is not a power of two.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_dat   = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (r_gnt == GW'(k)) begin
                w_sel_valid = i_valid[k];
                w_sel_dat   = i_dat[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Once granted, the path is a combinational pass-through. In IDLE it is
    // fully closed, which gives the one-cycle bubble between packets.
    always_comb begin
        o_valid = 1'b0;
        o_dat   = '0;
        i_ready = '0;
        if (r_state != ARB_IDLE) begin
            o_valid = w_sel_valid;
            o_dat   = w_sel_valid ? w_sel_dat : '0;
            for (int k = 0; k < N_PORTS; k++) begin
                if (r_gnt == GW'(k)) begin
                    i_ready[k] = o_ready;
                end
            end
        end
    end

    assign w_xfer   = o_valid & o_ready;
    assign w_len    = w_sel_dat[LEN_LSB +: LEN_W];
    assign o_gnt_id = r_gnt;
    assign o_busy   = (r_state != ARB_IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= ARB_IDLE;
            r_gnt    <= '0;
            r_last   <= GW'(N_PORTS - 1);
            r_remain <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_pick;
                        r_state <= ARB_HEAD;
                    end
                end
                ARB_HEAD: begin
                    if (w_xfer) begin
                        if (w_len == '0) begin
                            r_last  <= r_gnt;
                            r_state <= ARB_IDLE;
                        end else begin
                            r_remain <= w_len;
                            r_state  <= ARB_BODY;
                        end
                    end
                end
                ARB_BODY: begin
                    if (w_xfer) begin
                        r_remain <= r_remain - LEN_W'(1);
                        if (r_remain == LEN_W'(1)) begin
                            r_last  <= r_gnt;
                            r_state <= ARB_IDLE;
                        end
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fwnoc_out_arb.sv
// ----------------------------------------------------------------------------
// tb_fwnoc_out_arb
// Directed bench for the wormhole output arbiter with 4 ports and 32-bit
// flits. Inputs change 1 time unit after a rising edge, and outputs are
// sampled 1 time unit after that.
// ----------------------------------------------------------------------------
module tb_fwnoc_out_arb;

    logic        clock;
    logic        reset;
    logic [3:0]  vld;
    logic [3:0]  i_ready;
    logic [31:0] dat [4];
    logic [127:0] i_dat;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] o_dat;
    logic [1:0]  o_gnt_id;
    logic        o_busy;

    int vectors = 0;
    int fails   = 0;

    assign i_dat = {dat[3], dat[2], dat[1], dat[0]};

    fwnoc_out_arb #(
        .N_PORTS    (4),
        .DATA_WIDTH (32),
        .LEN_LSB    (0),
        .LEN_W      (8)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .i_valid  (vld),
        .i_ready  (i_ready),
        .i_dat    (i_dat),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .o_dat    (o_dat),
        .o_gnt_id (o_gnt_id),
        .o_busy   (o_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 64'(o_valid), 64'd0);
        chk({tag, "_busy"},  64'(o_busy),  64'd0);
        chk({tag, "_ready"}, 64'(i_ready), 64'd0);
        chk({tag, "_dat"},   64'(o_dat),   64'd0);
    endtask

    initial begin
        reset   = 1'b0;
        vld     = '0;
        o_ready = 1'b0;
        for (int k = 0; k < 4; k++) dat[k] = '0;

        // ---- reset state ----
        tick(); tick();
        #1;
        chk_idle("rst");
        chk("rst_gnt", 64'(o_gnt_id), 64'd0);
        tick();
        reset = 1'b1;

        // ---- fairness: all ports send L=0 packets ----
        tick();
        vld = 4'hF;
        o_ready = 1'b1;
        for (int k = 0; k < 4; k++) dat[k] = 32'h0000_0100 * (k + 1);
        #1;
        chk_idle("fair_arb0");
        for (int g = 0; g < 6; g++) begin
            tick();
            #1;
            chk("fair_gnt",   64'(o_gnt_id), 64'(g % 4));
            chk("fair_busy",  64'(o_busy),   64'd1);
            chk("fair_dat",   64'(o_dat),    64'(32'h0000_0100 * ((g % 4) + 1)));
            chk("fair_ready", 64'(i_ready),  64'(4'b0001 << (g % 4)));
            tick();
            #1;
            chk_idle("fair_gap");
        end
        vld = '0;

        // ---- single packet from port 2, L=3 ----
        tick();
        vld[2] = 1'b1;
        dat[2] = 32'hA5A5_0003;
        #1;
        chk_idle("single_arb");
        tick();
        #1;
        chk("single_gnt",   64'(o_gnt_id), 64'd2);
        chk("single_busy",  64'(o_busy),   64'd1);
        chk("single_valid", 64'(o_valid),  64'd1);
        chk("single_hdr",   64'(o_dat),    64'hA5A5_0003);
        chk("single_ready", 64'(i_ready),  64'b0100);
        for (int p = 1; p <= 3; p++) begin
            tick();
            dat[2] = 32'hB000_0000 + p;
            #1;
            chk("single_body_v", 64'(o_valid), 64'd1);
            chk("single_body",   64'(o_dat),   64'(32'hB000_0000 + p));
        end
        tick();
        vld = '0;
        #1;
        chk_idle("single_done");

        // ---- interleave guard: port 0 L=4, port 1 requests mid-packet ----
        tick();
        vld = 4'b0001;
        dat[0] = 32'hC000_0004;
        #1;
        chk_idle("ilv_arb");
        tick();
        #1;
        chk("ilv_gnt", 64'(o_gnt_id), 64'd0);
        chk("ilv_hdr", 64'(o_dat),    64'hC000_0004);
        for (int p = 1; p <= 4; p++) begin
            tick();
            dat[0] = 32'hC100_0000 + p;
            vld    = 4'b0011;
            dat[1] = 32'hD000_0000;
            #1;
            chk("ilv_body",  64'(o_dat),    64'(32'hC100_0000 + p));
            chk("ilv_gnt0",  64'(o_gnt_id), 64'd0);
            chk("ilv_ready", 64'(i_ready),  64'b0001);
        end
        tick();
        vld = 4'b0010;
        #1;
        chk_idle("ilv_gap");
        tick();
        #1;
        chk("ilv_gnt1",  64'(o_gnt_id), 64'd1);
        chk("ilv_hdr1",  64'(o_dat),    64'hD000_0000);
        chk("ilv_rdy1",  64'(i_ready),  64'b0010);
        tick();
        vld = '0;
        #1;
        chk_idle("ilv_done");

        // ---- backpressure: port 3, L=2, o_ready 1,0,0,1,0,1 ----
        tick();
        vld = 4'b1000;
        dat[3] = 32'hE000_0002;
        o_ready = 1'b1;
        #1;
        chk_idle("bp_arb");
        tick();
        o_ready = 1'b1;
        #1;
        chk("bp_gnt",  64'(o_gnt_id), 64'd3);
        chk("bp_hdr",  64'(o_dat),    64'hE000_0002);
        chk("bp_rdy0", 64'(i_ready),  64'b1000);
        tick();
        dat[3] = 32'hE100_0001;
        o_ready = 1'b0;
        #1;
        chk("bp_p1a",   64'(o_dat),   64'hE100_0001);
        chk("bp_rdy1",  64'(i_ready), 64'b0000);
        tick();
        #1;
        chk("bp_busy2", 64'(o_busy),  64'd1);
        chk("bp_p1b",   64'(o_dat),   64'hE100_0001);
        tick();
        o_ready = 1'b1;
        #1;
        chk("bp_busy3", 64'(o_busy),  64'd1);
        chk("bp_p1c",   64'(o_dat),   64'hE100_0001);
        chk("bp_rdy3",  64'(i_ready), 64'b1000);
        tick();
        dat[3] = 32'hE200_0002;
        o_ready = 1'b0;
        #1;
        chk("bp_busy4", 64'(o_busy),  64'd1);
        chk("bp_p2a",   64'(o_dat),   64'hE200_0002);
        tick();
        o_ready = 1'b1;
        #1;
        chk("bp_busy5", 64'(o_busy),  64'd1);
        chk("bp_p2b",   64'(o_dat),   64'hE200_0002);
        tick();
        vld = '0;
        #1;
        chk_idle("bp_done");

        // ---- max length: port 3, L=255 ----
        tick();
        vld = 4'b1000;
        dat[3] = 32'h3300_00FF;
        #1;
        chk_idle("max_arb");
        tick();
        #1;
        chk("max_gnt", 64'(o_gnt_id), 64'd3);
        chk("max_hdr", 64'(o_dat),    64'h3300_00FF);
        for (int p = 1; p <= 255; p++) begin
            tick();
            dat[3] = 32'h3000_0000 + p;
            #1;
            chk("max_body", 64'(o_dat),  64'(32'h3000_0000 + p));
            chk("max_busy", 64'(o_busy), 64'd1);
        end
        tick();
        vld = 4'b1001;
        dat[0] = 32'h4400_0000;
        dat[3] = 32'h3300_0000;
        #1;
        chk_idle("max_done");
        tick();
        #1;
        chk("max_next_gnt", 64'(o_gnt_id), 64'd0);
        chk("max_next_hdr", 64'(o_dat),    64'h4400_0000);
        tick();
        vld = '0;
        #1;
        chk_idle("max_next_done");

        // ---- reset mid-packet: port 1, L=5 ----
        tick();
        vld = 4'b0010;
        dat[1] = 32'h5500_0005;
        #1;
        chk_idle("mrst_arb");
        tick();
        #1;
        chk("mrst_gnt", 64'(o_gnt_id), 64'd1);
        chk("mrst_hdr", 64'(o_dat),    64'h5500_0005);
        tick();
        dat[1] = 32'h5600_0001;
        #1;
        chk("mrst_b1", 64'(o_dat), 64'h5600_0001);
        tick();
        dat[1] = 32'h5600_0002;
        #1;
        chk("mrst_b2_v", 64'(o_valid), 64'd1);
        reset = 1'b0;
        #1;
        chk_idle("mrst_now");
        chk("mrst_gnt0", 64'(o_gnt_id), 64'd0);
        tick();
        reset = 1'b1;
        vld = 4'b0011;
        dat[0] = 32'h6600_0000;
        dat[1] = 32'h5500_0005;
        #1;
        chk_idle("mrst_rel");
        tick();
        #1;
        chk("mrst_new_gnt", 64'(o_gnt_id), 64'd0);
        chk("mrst_new_hdr", 64'(o_dat),    64'h6600_0000);
        chk("mrst_new_rdy", 64'(i_ready),  64'b0001);
        tick();
        vld = '0;
        #1;
        chk_idle("mrst_done");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
